pixel_scheduler: RTL and testbench

Frame-level controller that scans a WIDTH x HEIGHT pixel raster and maps each pixel to a complex coordinate c. It farms the pixels out round-robin to NUM_ENGINES escape-depth engines, each using the existing start/done/final_depth handshake. It retires results strictly in raster order onto a valid/ready pixel stream for the video/DMA path. It is the only block that drives the engines' start, x, y, re_c and im_c inputs.

---
 rtl/pixel_sched_pkg.sv | 21 ++
 rtl/coord_stepper.sv | 79 +++++++
 rtl/pixel_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_pixel_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_sched_pkg.sv
// Shared types and field widths for the pixel scheduler and its coordinate stepper.
package pixel_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        LAUNCHED = 2'd1,
        ARMED    = 2'd2,
        RESULT   = 2'd3
    } eng_state_t;

    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int DEPTH_W = 8;

endpackage

// File: rtl/coord_stepper.sv
// Raster x/y counter with optional incremental complex-coordinate accumulator (no multiplier).
module coord_stepper
    import pixel_sched_pkg::*;
#(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter bit WITH_COORD = 1'b1
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic               load,
    input  logic               advance,
    input  logic signed [31:0] re_origin,
    input  logic signed [31:0] im_origin,
    input  logic signed [31:0] step,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic signed [31:0] re_c,
    output logic signed [31:0] im_c,
    output logic               last
);

    logic eol;

    assign eol  = (x == X_W'(WIDTH - 1));
    assign last = eol && (y == Y_W'(HEIGHT - 1));

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (load) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (eol) begin
                x <= '0;
                y <= (y == Y_W'(HEIGHT - 1)) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    generate
        if (WITH_COORD) begin : g_coord
            logic signed [31:0] re_base;
            logic signed [31:0] step_r;

            // Wrapping two's-complement arithmetic; the line start reloads from the latched origin.
            always_ff @(posedge sysclk or posedge reset) begin
                if (reset) begin
                    re_base <= '0;
                    step_r  <= '0;
                    re_c    <= '0;
                    im_c    <= '0;
                end else if (load) begin
                    re_base <= re_origin;
                    step_r  <= step;
                    re_c    <= re_origin;
                    im_c    <= im_origin;
                end else if (advance) begin
                    if (eol) begin
                        re_c <= re_base;
                        im_c <= im_c - step_r;
                    end else begin
                        re_c <= re_c + step_r;
                    end
                end
            end
        end else begin : g_no_coord
            logic unused_coord;
            assign unused_coord = ^{re_origin, im_origin, step};
            assign re_c = '0;
            assign im_c = '0;
        end
    endgenerate

endmodule

// File: rtl/pixel_scheduler.sv
// Frame scheduler: dispatches raster pixels round-robin to depth engines and retires
// their results in raster order onto a valid/ready pixel stream.
module pixel_scheduler
    import pixel_sched_pkg::*;
#(
    parameter int NUM_ENGINES = 4,
    parameter int FRAC        = 16,
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480
) (
    input  logic                           sysclk,
    input  logic                           reset,
    input  logic                           frame_start,
    input  logic signed [31:0]             re_origin,
    input  logic signed [31:0]             im_origin,
    input  logic signed [31:0]             step,
    output logic                           busy,
    output logic                           frame_done,
    output logic [NUM_ENGINES-1:0]         eng_start,
    output logic [X_W-1:0]                 eng_x,
    output logic [Y_W-1:0]                 eng_y,
    output logic signed [31:0]             eng_re_c,
    output logic signed [31:0]             eng_im_c,
    input  logic [NUM_ENGINES-1:0]         eng_done,
    input  logic [DEPTH_W*NUM_ENGINES-1:0] eng_depth,
    output logic                           pix_valid,
    input  logic                           pix_ready,
    output logic [DEPTH_W-1:0]             pix_depth,
    output logic [X_W-1:0]                 pix_x,
    output logic [Y_W-1:0]                 pix_y,
    output logic                           pix_sof,
    output logic                           pix_eol
);

    localparam int PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

    sched_state_t       state;
    eng_state_t         eng_st [NUM_ENGINES];
    logic [PTR_W-1:0]   disp_ptr;
    logic [PTR_W-1:0]   ret_ptr;
    logic               load;
    logic               dispatch;
    logic               retire;
    logic               accept;
    logic               pix_last;
    logic [X_W-1:0]     disp_x;
    logic [Y_W-1:0]     disp_y;
    logic [X_W-1:0]     ret_x;
    logic [Y_W-1:0]     ret_y;
    logic signed [31:0] disp_re;
    logic signed [31:0] disp_im;
    logic signed [31:0] unused_ret_re;
    logic signed [31:0] unused_ret_im;
    logic               disp_last;
    logic               unused_ret_last;
    logic [DEPTH_W-1:0] ret_depth;
    logic [31:0]        unused_frac;

    // Coordinates are opaque to the scheduler; FRAC only names the engines' number format.
    assign unused_frac = 32'(FRAC);

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_ENGINES - 1)) ? '0 : p + 1'b1;
    endfunction

    assign load       = (state == IDLE) && frame_start;
    assign dispatch   = (state == RUN) && (eng_st[disp_ptr] == FREE);
    assign accept     = pix_valid && pix_ready;
    assign retire     = (state != IDLE) && (eng_st[ret_ptr] == RESULT) && (!pix_valid || pix_ready);
    assign frame_done = accept && pix_last && (state == DRAIN);

    always_comb begin
        ret_depth = '0;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            if (ret_ptr == PTR_W'(k)) ret_depth = eng_depth[k*DEPTH_W +: DEPTH_W];
        end
    end

    coord_stepper #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .WITH_COORD(1'b1)) u_disp_step (
        .sysclk    (sysclk),
        .reset     (reset),
        .load      (load),
        .advance   (dispatch),
        .re_origin (re_origin),
        .im_origin (im_origin),
        .step      (step),
        .x         (disp_x),
        .y         (disp_y),
        .re_c      (disp_re),
        .im_c      (disp_im),
        .last      (disp_last)
    );

    coord_stepper #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .WITH_COORD(1'b0)) u_ret_step (
        .sysclk    (sysclk),
        .reset     (reset),
        .load      (load),
        .advance   (retire),
        .re_origin ('0),
        .im_origin ('0),
        .step      ('0),
        .x         (ret_x),
        .y         (ret_y),
        .re_c      (unused_ret_re),
        .im_c      (unused_ret_im),
        .last      (unused_ret_last)
    );

    // A launched engine must show done low before a high done counts as its result,
    // so a level left over from the previous pixel is never taken as new.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_ENGINES; k++) eng_st[k] <= FREE;
        end else begin
            for (int k = 0; k < NUM_ENGINES; k++) begin
                case (eng_st[k])
                    FREE:     if (dispatch && disp_ptr == PTR_W'(k)) eng_st[k] <= LAUNCHED;
                    LAUNCHED: if (!eng_done[k]) eng_st[k] <= ARMED;
                    ARMED:    if (eng_done[k]) eng_st[k] <= RESULT;
                    RESULT:   if (retire && ret_ptr == PTR_W'(k)) eng_st[k] <= FREE;
                endcase
            end
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            disp_ptr  <= '0;
            ret_ptr   <= '0;
            eng_start <= '0;
            eng_x     <= '0;
            eng_y     <= '0;
            eng_re_c  <= '0;
            eng_im_c  <= '0;
            pix_valid <= 1'b0;
            pix_depth <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;
            pix_last  <= 1'b0;
        end else begin
            eng_start <= '0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        disp_ptr <= '0;
                        ret_ptr  <= '0;
                    end
                end
                RUN: begin
                    if (dispatch && disp_last) state <= DRAIN;
                end
                DRAIN: begin
                    if (frame_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (dispatch) begin
                eng_start <= NUM_ENGINES'(1) << disp_ptr;
                eng_x     <= disp_x;
                eng_y     <= disp_y;
                eng_re_c  <= disp_re;
                eng_im_c  <= disp_im;
                disp_ptr  <= next_ptr(disp_ptr);
            end

            // Output register refills only when empty or being accepted in this cycle.
            if (retire) begin
                pix_valid <= 1'b1;
                pix_depth <= ret_depth;
                pix_x     <= ret_x;
                pix_y     <= ret_y;
                pix_sof   <= (ret_x == '0) && (ret_y == '0);
                pix_eol   <= (ret_x == X_W'(WIDTH - 1));
                pix_last  <= (ret_x == X_W'(WIDTH - 1)) && (ret_y == Y_W'(HEIGHT - 1));
                ret_ptr   <= next_ptr(ret_ptr);
            end else if (accept) begin
                pix_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pixel_scheduler.sv
// Scoreboard bench for pixel_scheduler on a 4x2 raster with two modelled depth engines.
module tb_pixel_scheduler;

    localparam int NE = 2;
    localparam int W  = 4;
    localparam int H  = 2;

    logic        sysclk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [31:0] re_origin = '0;
    logic [31:0] im_origin = '0;
    logic [31:0] step = '0;
    logic        busy, frame_done;
    logic [1:0]  eng_start;
    logic [9:0]  eng_x;
    logic [8:0]  eng_y;
    logic [31:0] eng_re_c, eng_im_c;
    logic [1:0]  eng_done;
    logic [15:0] eng_depth;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic [7:0]  pix_depth;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        pix_sof, pix_eol;

    pixel_scheduler #(.NUM_ENGINES(NE), .FRAC(16), .WIDTH(W), .HEIGHT(H)) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .frame_start (frame_start),
        .re_origin   (re_origin),
        .im_origin   (im_origin),
        .step        (step),
        .busy        (busy),
        .frame_done  (frame_done),
        .eng_start   (eng_start),
        .eng_x       (eng_x),
        .eng_y       (eng_y),
        .eng_re_c    (eng_re_c),
        .eng_im_c    (eng_im_c),
        .eng_done    (eng_done),
        .eng_depth   (eng_depth),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_depth   (pix_depth),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_sof     (pix_sof),
        .pix_eol     (pix_eol)
    );

    always #5 sysclk = ~sysclk;

    int n_vec = 0;
    int n_miss = 0;
    int done_cnt = 0;
    int disp_cnt = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Engine model: done drops on start, rises after the latency with depth = x + 4*y.
    logic [1:0] m_done = '0;
    logic [1:0] m_run = '0;
    logic [7:0] m_dep [NE];
    logic [7:0] m_pend [NE];
    int         m_cnt [NE];
    int         fix_lat = 3;
    logic       rand_lat = 1'b0;
    logic       stale_req = 1'b0;

    assign eng_done  = m_done;
    assign eng_depth = {m_dep[1], m_dep[0]};

    initial begin
        for (int k = 0; k < NE; k++) begin
            m_dep[k]  = 8'h00;
            m_pend[k] = 8'h00;
            m_cnt[k]  = 0;
        end
    end

    always @(posedge sysclk) begin
        for (int k = 0; k < NE; k++) begin
            if (stale_req) begin
                m_done[k] <= 1'b1;
                m_run[k]  <= 1'b0;
                m_dep[k]  <= 8'hEE;
            end else if (eng_start[k]) begin
                m_done[k] <= 1'b0;
                m_run[k]  <= 1'b1;
                m_cnt[k]  <= rand_lat ? int'($urandom_range(1, 20)) : fix_lat;
                m_pend[k] <= 8'(eng_x) + 8'(eng_y) * 8'd4;
            end else if (m_run[k]) begin
                if (m_cnt[k] <= 1) begin
                    m_done[k] <= 1'b1;
                    m_dep[k]  <= m_pend[k];
                    m_run[k]  <= 1'b0;
                end else begin
                    m_cnt[k] <= m_cnt[k] - 1;
                end
            end
        end
    end

    // Scoreboard queues: dispatch {start, x, y, re, im}; pixel {depth, x, y, sof, eol, last}.
    logic [84:0] dispq [$];
    logic [29:0] pixq [$];
    logic [29:0] e_pix;
    logic [84:0] e_disp;
    logic        exp_done;
    logic        hold_prev = 1'b0;
    logic [30:0] prev_pix;
    logic [30:0] cur_pix;

    always @(negedge sysclk) begin
        if (reset) begin
            hold_prev = 1'b0;
        end else begin
            cur_pix = {pix_valid, pix_depth, pix_x, pix_y, pix_sof, pix_eol};
            if (eng_start != 2'b00) begin
                disp_cnt++;
                chk("dispq_has_entry", dispq.size() > 0, 1'b1);
                if (dispq.size() > 0) begin
                    e_disp = dispq.pop_front();
                    chk("dispatch", {eng_start, eng_x, eng_y, eng_re_c, eng_im_c}, e_disp);
                end
            end
            if (hold_prev) chk("pix_hold", cur_pix, prev_pix);
            exp_done = 1'b0;
            if (pix_valid && pix_ready) begin
                chk("pixq_has_entry", pixq.size() > 0, 1'b1);
                if (pixq.size() > 0) begin
                    e_pix = pixq.pop_front();
                    chk("pixel", {pix_depth, pix_x, pix_y, pix_sof, pix_eol}, e_pix[29:1]);
                    exp_done = e_pix[0];
                    if (e_pix[0]) begin
                        chk("busy_at_done", busy, 1'b1);
                        done_cnt++;
                    end
                end
            end
            if (exp_done || frame_done) chk("frame_done", frame_done, exp_done);
            hold_prev = pix_valid && !pix_ready;
            prev_pix  = cur_pix;
        end
    end

    task automatic issue_frame(input logic [31:0] ro, input logic [31:0] io, input logic [31:0] st);
        logic [9:0] x;
        logic [8:0] y;
        for (int n = 0; n < W * H; n++) begin
            x = 10'(n % W);
            y = 9'(n / W);
            dispq.push_back({2'b01 << (n % NE), x, y, ro + 32'(n % W) * st, io - 32'(n / W) * st});
            pixq.push_back({8'(n), x, y, n == 0, x == 10'(W - 1), n == W * H - 1});
        end
        @(posedge sysclk); #1;
        frame_start = 1'b1;
        re_origin   = ro;
        im_origin   = io;
        step        = st;
        @(posedge sysclk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_frame(input string nm);
        int base;
        int cyc;
        base = done_cnt;
        cyc  = 0;
        while (done_cnt == base && cyc < 3000) begin
            @(posedge sysclk);
            cyc++;
        end
        chk({nm, "_frames_done"}, 128'(done_cnt - base), 128'd1);
        @(negedge sysclk);
        chk({nm, "_busy_after"}, busy, 1'b0);
        chk({nm, "_pixq_left"}, 128'(pixq.size()), 128'd0);
        chk({nm, "_dispq_left"}, 128'(dispq.size()), 128'd0);
    endtask

    initial begin
        int cyc;
        int base;
        repeat (3) @(posedge sysclk);
        #1;
        chk("reset_outputs", {busy, frame_done, eng_start, eng_x, eng_y, eng_re_c, eng_im_c,
                              pix_valid, pix_depth, pix_x, pix_y, pix_sof, pix_eol}, '0);
        reset = 1'b0;

        // Frame A: fixed latency 3, hand values re -2.0 .. -0.5, im 1.0 then 0.5.
        fix_lat = 3;
        issue_frame(32'hFFFE0000, 32'h00010000, 32'h00008000);
        @(negedge sysclk);
        chk("busy_in_frame", busy, 1'b1);
        wait_frame("frameA");

        // Frame B: random latency; re and im both wrap through the signed limits.
        rand_lat = 1'b1;
        issue_frame(32'h7FFF0000, 32'h80000000, 32'h00010000);
        wait_frame("frameB");

        // Frame C: downstream stall mid-frame plus an ignored frame_start.
        issue_frame(32'h00100000, 32'hFFFE0000, 32'hFFFF8000);
        cyc = 0;
        while (pixq.size() > 6 && cyc < 500) begin
            @(posedge sysclk);
            cyc++;
        end
        chk("stall_point_reached", pixq.size() <= 6, 1'b1);
        #1;
        pix_ready   = 1'b0;
        frame_start = 1'b1;
        re_origin   = 32'h12345678;
        im_origin   = 32'h0BADF00D;
        step        = 32'h00000100;
        @(posedge sysclk); #1;
        frame_start = 1'b0;
        repeat (9) @(posedge sysclk);
        #1;
        pix_ready = 1'b1;
        wait_frame("frameC");

        // Frame D: stale done with a bogus depth on both engines before launch; latency 1.
        rand_lat = 1'b0;
        fix_lat  = 1;
        @(posedge sysclk); #1;
        stale_req = 1'b1;
        @(posedge sysclk); #1;
        stale_req = 1'b0;
        issue_frame(32'h00000000, 32'h00000000, 32'h00000001);
        wait_frame("frameD");

        // Frame E: async reset with three pixels outstanding, then a full fresh frame.
        fix_lat   = 3;
        pix_ready = 1'b0;
        base      = disp_cnt;
        issue_frame(32'h00050000, 32'h00060000, 32'h00001000);
        cyc = 0;
        while (disp_cnt < base + 3 && cyc < 500) begin
            @(posedge sysclk);
            cyc++;
        end
        chk("three_dispatched", disp_cnt >= base + 3, 1'b1);
        @(posedge sysclk); #2;
        reset = 1'b1;
        #1;
        chk("midframe_reset_outputs", {busy, frame_done, eng_start, eng_x, eng_y, eng_re_c, eng_im_c,
                                       pix_valid, pix_depth, pix_x, pix_y, pix_sof, pix_eol}, '0);
        dispq.delete();
        pixq.delete();
        repeat (3) @(posedge sysclk);
        #1;
        reset     = 1'b0;
        pix_ready = 1'b1;
        rand_lat  = 1'b1;
        issue_frame(32'hFFFE0000, 32'h00010000, 32'h00008000);
        wait_frame("frameF");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
